uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports 5-9 data bits, none/odd/even parity and 1 or 2 stop bits. It reports parity error, framing error, break and overrun, and holds each received word in an output register with a valid/ready handshake. It sits between the serial input pin and the command/byte parser of the NLFSR host interface.

Parameters:
CLKS_PER_BIT, 35, clock cycles per serial bit (>= 8).
DATA_BITS, 8, data bits per frame (5..9).
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked per frame (1 or 2).

Ports:
i_Clock  in  1  system clock; the only clock.
i_Rst_n  in  1  synchronous reset, active-low.
i_Rx_Serial  in  1  asynchronous serial line, idle high.
i_Rx_Ready  in  1  consumer accepts the held word this cycle.
o_Rx_DV  out  1  held word valid; level, stays high until accepted.
o_Rx_Data  out  DATA_BITS  received word, LSB = first bit on the line.
o_Parity_Err  out  1  held word failed parity check; qualified by o_Rx_DV.
o_Frame_Err  out  1  a stop bit sampled 0; qualified by o_Rx_DV.
o_Break  out  1  held word is a break condition; qualified by o_Rx_DV.
o_Overrun  out  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (i_Rst_n=0 at a clock edge): FSM to IDLE, counters 0, both synchroniser flops 1, o_Rx_DV/o_Rx_Data/all flags/o_Overrun 0. Reset mid-frame abandons the frame with no output.
- Input path: 2-flop synchroniser; the FSM uses only the second flop (rx_s).
- Bit timer width: $clog2(CLKS_PER_BIT)+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: on rx_s=0, clear the counter and go to START.
- START: count to (CLKS_PER_BIT-1)/2, then sample. rx_s=0 goes to DATA with counter 0. rx_s=1 is a glitch: return to IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles, shifting LSB first. After DATA_BITS samples go to PARITY (PARITY!=0) or STOP.
- PARITY: sample one bit. Error if the XOR of data and parity bit is 0 for odd, or 1 for even.
- STOP: sample STOP_BITS bits at mid-bit. Any 0 sets the frame error.
  - After the last stop sample, commit the word and go to IDLE directly (no extra cleanup cycle), leaving half a bit of resync margin.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - Commit with o_Break=1, o_Frame_Err=1, o_Parity_Err=0.
  - Then go to BRK_WAIT, which stays until rx_s=1, then IDLE.
- Commit (the cycle after the final stop-bit sample):
  - If o_Rx_DV=0, or o_Rx_DV=1 and i_Rx_Ready=1 in the same cycle: load o_Rx_Data and flags, o_Rx_DV=1.
  - Else the held word is unchanged, the new word is discarded and o_Overrun pulses for 1 cycle.
- Handshake: o_Rx_DV & i_Rx_Ready accepts the word. o_Rx_DV drops next cycle unless a commit coincides (then stays 1 with new data). i_Rx_Ready while o_Rx_DV=0 is ignored.
- o_Rx_Data and flags are stable while o_Rx_DV=1.
- Latency: o_Rx_DV rises 2 + (CLKS_PER_BIT-1)/2 + CLKS_PER_BIT*(DATA_BITS + (PARITY!=0) + STOP_BITS) + 1 cycles after the line falls (±1 for the synchroniser phase).
- Line held low in IDLE after BRK_WAIT exit cannot occur; BRK_WAIT only exits on high.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (localparams, 3 bits);
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - a parameter-legality check function used by an initial assertion on DATA_BITS, PARITY, STOP_BITS and CLKS_PER_BIT.
- One sub-module: uart_bit_timer (counter with half-bit and full-bit tick outputs, clear input), reused by the planned parametrised transmitter.

Test Plan:
- Defaults (35, 8N1), send 0xA5 with i_Rx_Ready=1 -> o_Rx_DV 1 cycle, o_Rx_Data=0xA5, all flags 0, latency within ±1 of the formula.
- DATA_BITS=7, PARITY=2, send 0x41 with parity bit 0 -> o_Rx_Data=0x41, no error; repeat with parity bit 1 -> o_Parity_Err=1.
- STOP_BITS=2, second stop bit driven 0 on 0x3C -> o_Rx_Data=0x3C, o_Frame_Err=1.
- Line low for 15 bit times, then high -> one word 0x00 with o_Break=1 and o_Frame_Err=1. No further word until the next falling edge after high; the next frame 0x55 is received correctly.
- i_Rx_Ready=0, send 0x11 then 0x22 -> o_Rx_DV stays 1 with 0x11, o_Overrun pulses once at the 0x22 commit. Raise ready -> o_Rx_DV drops; then 0x33 is received normally.
- Low glitch of 10 cycles in IDLE -> no output. Reset asserted mid-DATA of a 0xFF frame -> all outputs 0; the next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and parameter checks
// for the parametrised UART blocks.
package uart_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_BRK_WAIT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_START    = S_START,
    ST_DATA     = S_DATA,
    ST_PARITY   = S_PARITY,
    ST_STOP     = S_STOP,
    ST_BRK_WAIT = S_BRK_WAIT
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic params_ok(
    input int cpb,
    input int db,
    input int par,
    input int sb
  );
    return (cpb >= 8) && (db >= 5) && (db <= 9) &&
           (par >= PAR_NONE) && (par <= PAR_EVEN) &&
           ((sb == 1) || (sb == 2));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter
// with mid-bit and end-of-bit ticks.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 35
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  output logic o_Half_Tick,
  output logic o_Full_Tick
);

  localparam int W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [W-1:0] HALF = W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n || i_Clear) begin
      cnt <= '0;
    end else if (o_Full_Tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_Half_Tick = (cnt == HALF);
  assign o_Full_Tick = (cnt == FULL);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with parity, framing,
// break and overrun reporting behind a valid/ready word register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 35,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (!params_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS))
  begin : g_bad_params
    $error("uart_rx_frame: illegal parameter set");
  end

  rx_state_e state, state_nx;

  logic                 rx_m, rx_s;
  logic                 tmr_clr, half_tick, full_tick;
  logic                 shift_en, par_en, stop_en, commit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop1, ferr;
  logic                 first_stop, brk, par_err;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Clear    (tmr_clr),
    .o_Half_Tick(half_tick),
    .o_Full_Tick(full_tick)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmr_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (!rx_s) state_nx = ST_START;
      end
      ST_START: begin
        if (half_tick) begin
          tmr_clr  = 1'b1;
          state_nx = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT)
            state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (full_tick) begin
          par_en   = 1'b1;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_tick) begin
          stop_en = 1'b1;
          if (stop_cnt == LAST_STOP) begin
            commit   = 1'b1;
            state_nx = brk ? ST_BRK_WAIT : ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        tmr_clr = 1'b1;
        if (rx_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop1    <= 1'b1;
      ferr     <= 1'b0;
    end else if (state == ST_IDLE) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par_bit <= rx_s;
      if (stop_en) begin
        stop_cnt <= stop_cnt + 1'b1;
        if (!stop_cnt) stop1 <= rx_s;
        if (!rx_s)     ferr  <= 1'b1;
      end
    end
  end

  // Break looks at the first stop bit even with two stop bits
  assign first_stop = stop_cnt ? stop1 : rx_s;
  assign brk = (shreg == '0) && !par_bit && !first_stop;

  always_comb begin
    par_err = 1'b0;
    unique case (1'b1)
      PARITY == PAR_ODD:  par_err = ~(^shreg ^ par_bit);
      PARITY == PAR_EVEN: par_err = ^shreg ^ par_bit;
      default:            par_err = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      o_Rx_DV      <= 1'b0;
      o_Rx_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      o_Overrun <= 1'b0;
      if (commit && (!o_Rx_DV || i_Rx_Ready)) begin
        o_Rx_DV      <= 1'b1;
        o_Rx_Data    <= shreg;
        o_Break      <= brk;
        o_Frame_Err  <= brk | ferr | ~rx_s;
        o_Parity_Err <= ~brk & par_err;
      end else if (commit) begin
        o_Overrun <= 1'b1;
      end else if (i_Rx_Ready) begin
        o_Rx_DV <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: three receiver configurations (8N1, 7E1, 8N2)
// driven from a frame table plus hand-written corner sequences.
module tb_uart_rx_frame;

  localparam int CPB = 35;
  localparam int NB [3] = '{8, 7, 8};
  localparam int PM [3] = '{0, 2, 0};
  localparam int SB [3] = '{1, 1, 2};

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         t0;
    bit         chk_lat;
  } exp_t;

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       pbit;
    int         bad_stop;
    logic       perr;
    logic       ferr;
    logic       brk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b111;
  wire  [2:0] dv, perr, ferr, brk, ovr;
  wire  [7:0] d0;
  wire  [6:0] d1;
  wire  [7:0] d2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   words [3] = '{0, 0, 0};
  int   ovr_cnt [3] = '{0, 0, 0};
  exp_t sb [$];
  vec_t tv [12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Rx_Serial(rx[0]), .i_Rx_Ready(rdy[0]),
    .o_Rx_DV(dv[0]), .o_Rx_Data(d0),
    .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
    .o_Break(brk[0]), .o_Overrun(ovr[0])
  );

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1)
  ) u1 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Rx_Serial(rx[1]), .i_Rx_Ready(rdy[1]),
    .o_Rx_DV(dv[1]), .o_Rx_Data(d1),
    .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
    .o_Break(brk[1]), .o_Overrun(ovr[1])
  );

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(2)
  ) u2 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Rx_Serial(rx[2]), .i_Rx_Ready(rdy[2]),
    .o_Rx_DV(dv[2]), .o_Rx_Data(d2),
    .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]),
    .o_Break(brk[2]), .o_Overrun(ovr[2])
  );

  function automatic logic [8:0] dat(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {2'b00, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return 2 + (CPB - 1) / 2 +
           CPB * (NB[k] + (PM[k] != 0 ? 1 : 0) + SB[k]) + 1;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ovr[k]) ovr_cnt[k]++;
      if (dv[k] && rdy[k]) begin
        exp_t e;
        words[k]++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: dut %0d data 0x%0h, none expected",
                   k, dat(k));
        end else begin
          int lat;
          e = sb.pop_front();
          check("word_dut", k, e.k);
          check("word_data", dat(k), e.data);
          check("word_perr", perr[k], e.perr);
          check("word_ferr", ferr[k], e.ferr);
          check("word_brk", brk[k], e.brk);
          if (e.chk_lat) begin
            lat = cyc - e.t0;
            n_checks++;
            if (lat < lat_of(k) - 1 || lat > lat_of(k) + 1) begin
              n_fail++;
              $display("FAIL latency: got %0d, expected %0d +/-1",
                       lat, lat_of(k));
            end
          end
        end
      end
    end
  end

  task automatic send_frame(input int k, input logic [8:0] d,
                            input logic pbit, input int bad_stop);
    logic [15:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < NB[k]; i++) begin
      b[n] = d[i];
      n++;
    end
    if (PM[k] != 0) begin
      b[n] = pbit;
      n++;
    end
    for (int s = 0; s < SB[k]; s++) begin
      b[n] = (s != bad_stop);
      n++;
    end
    for (int i = 0; i < n; i++) begin
      rx[k] = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx[k] = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 4 * CPB && sb.size() != 0; c++)
      @(posedge clk);
    #1;
    check(nm, sb.size(), 0);
  endtask

  task automatic run_one(input vec_t v, input bit chk_lat);
    exp_t e;
    @(posedge clk);
    #1;
    e = '{v.k, v.data, v.perr, v.ferr, v.brk, cyc, chk_lat};
    sb.push_back(e);
    send_frame(v.k, v.data, v.pbit, v.bad_stop);
    wait_drain("drain");
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_t e;
    vec_t v;

    tv[0]  = '{0, 9'h0A5, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{0, 9'h000, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{0, 9'h0FF, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{0, 9'h05A, 1'b0,  0, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{1, 9'h041, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1, 9'h041, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1, 9'h000, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1, 9'h07F, 1'b1, -1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1, 9'h000, 1'b0,  0, 1'b0, 1'b1, 1'b1};
    tv[9]  = '{2, 9'h03C, 1'b0,  1, 1'b0, 1'b1, 1'b0};
    tv[10] = '{2, 9'h0C3, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{2, 9'h000, 1'b0,  0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dv", dv, 3'b000);
    check("rst_perr", perr, 3'b000);
    check("rst_ferr", ferr, 3'b000);
    check("rst_brk", brk, 3'b000);
    check("rst_ovr", ovr, 3'b000);
    check("rst_data0", d0, 8'h00);
    check("rst_data1", d1, 7'h00);
    check("rst_data2", d2, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    foreach (tv[i]) run_one(tv[i], 1'b1);

    // line held low well past a frame: one break word only
    base = words[0];
    @(posedge clk);
    #1;
    e = '{0, 9'h000, 1'b0, 1'b1, 1'b1, cyc, 1'b0};
    sb.push_back(e);
    rx[0] = 1'b0;
    repeat (15 * CPB) @(posedge clk);
    #1;
    check("brk_words", words[0] - base, 1);
    check("brk_drain", sb.size(), 0);
    rx[0] = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("brk_no_more", words[0] - base, 1);
    check("brk_dv_low", dv[0], 1'b0);
    v = '{0, 9'h055, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    run_one(v, 1'b1);

    // consumer stalled: second word dropped with one overrun pulse
    rdy[0] = 1'b0;
    base = ovr_cnt[0];
    @(posedge clk);
    #1;
    e = '{0, 9'h011, 1'b0, 1'b0, 1'b0, cyc, 1'b0};
    sb.push_back(e);
    send_frame(0, 9'h011, 1'b0, -1);
    check("ovr_none_yet", ovr_cnt[0] - base, 0);
    send_frame(0, 9'h022, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_dv_held", dv[0], 1'b1);
    check("ovr_data_held", d0, 8'h11);
    check("ovr_pulses", ovr_cnt[0] - base, 1);
    rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_popped", sb.size(), 0);
    check("ovr_dv_drop", dv[0], 1'b0);
    v = '{0, 9'h033, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    run_one(v, 1'b1);

    // short low glitch must not start a frame
    base = words[0];
    @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_words", words[0] - base, 0);
    check("glitch_dv", dv[0], 1'b0);

    // reset in the middle of an all-ones frame
    base = words[0];
    rx[0] = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_dv", dv, 3'b000);
    check("mid_rst_data", d0, 8'h00);
    check("mid_rst_flags", {perr[0], ferr[0], brk[0], ovr[0]}, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8 * CPB) @(posedge clk);
    #1;
    check("mid_rst_words", words[0] - base, 0);
    v = '{0, 9'h081, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    run_one(v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
